// File: rtl/load_store_unit.sv
//==============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory-stage load/store unit with a valid/ready memory port.
// Revision : 1.0
//==============================================================================
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_load_data;

    logic        w_legal_ld;
    logic        w_legal_st;
    logic        w_misalign;
    logic        w_fault_in;
    logic        w_noop;
    logic        w_accept;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    // Request decode, evaluated on the raw execute-stage inputs
    always_comb begin
        w_legal_ld = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
        w_legal_st = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        w_misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        w_fault_in = (is_load && is_store) ||
                     (is_load  && (!w_legal_ld || w_misalign)) ||
                     (is_store && (!w_legal_st || w_misalign));
        w_noop     = !is_load && !is_store;
        w_accept   = (r_state == S_IDLE) && start;
    end

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << alu_result[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << alu_result[1:0];
                w_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfwords are aligned by now, so lane bit 1 alone selects the half
    always_comb begin
        w_shifted = mem_rdata >> {r_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_ext = {16'd0, w_shifted[15:0]};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_fault_in || w_noop) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    w_next = r_we ? S_DONE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= 32'd0;
            r_lane      <= 2'd0;
            r_funct3    <= 3'd0;
            r_we        <= 1'b0;
            r_wstrb     <= 4'd0;
            r_wdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fault <= w_fault_in;
                // Faulting and no-op requests leave the memory port untouched
                if (!w_fault_in && !w_noop) begin
                    r_addr   <= {alu_result[31:2], 2'b00};
                    r_lane   <= alu_result[1:0];
                    r_funct3 <= funct3;
                    r_we     <= is_store;
                    r_wstrb  <= is_store ? w_strb : 4'd0;
                    r_wdata  <= is_store ? w_wdata : 32'd0;
                end
            end
            if ((r_state == S_WAIT_RSP) && mem_rsp_valid) begin
                r_load_data <= w_ext;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign fault         = (r_state == S_DONE) && r_fault;
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_addr      = r_addr;
    assign mem_we        = r_we;
    assign mem_wstrb     = r_wstrb;
    assign mem_wdata     = r_wdata;
    assign load_data     = r_load_data;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .is_load       (is_load),
        .is_store      (is_store),
        .funct3        (funct3),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .load_data     (load_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start pulse; returns at the negedge of cycle 1
    task automatic launch(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
        start      = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        alu_result = addr;
        store_data = data;
        @(negedge clk);
        start      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, fault, mem_req_valid, mem_we} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, fault, mem_req_valid, mem_we});
        end
        n_cmp++;
        if ({mem_wstrb, mem_addr, mem_wdata, load_data} !== 100'd0) begin
            n_err++;
            $display("FAIL reset_data: strb %h addr %h wdata %h ld %h expected all 0",
                     mem_wstrb, mem_addr, mem_wdata, load_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_b2b();
        logic [2:0]  f3s  [3];
        logic [31:0] adrs [3];
        logic [31:0] dats [3];
        logic [31:0] eadr [3];
        logic [3:0]  estb [3];
        logic [31:0] ewd  [3];
        f3s[0] = 3'b010; adrs[0] = 32'h100; dats[0] = 32'hDEADBEEF;
        eadr[0] = 32'h100; estb[0] = 4'b1111; ewd[0] = 32'hDEADBEEF;
        f3s[1] = 3'b000; adrs[1] = 32'h103; dats[1] = 32'h000000A5;
        eadr[1] = 32'h100; estb[1] = 4'b1000; ewd[1] = 32'hA5A5A5A5;
        f3s[2] = 3'b001; adrs[2] = 32'h102; dats[2] = 32'h0000BEEF;
        eadr[2] = 32'h100; estb[2] = 4'b1100; ewd[2] = 32'hBEEFBEEF;
        for (int i = 0; i < 3; i++) begin
            launch(1'b0, 1'b1, f3s[i], adrs[i], dats[i]);
            n_cmp++;
            if ({busy, mem_req_valid, mem_we} !== 3'b111) begin
                n_err++;
                $display("FAIL st%0d_req: busy/valid/we %b expected 111", i, {busy, mem_req_valid, mem_we});
            end
            n_cmp++;
            if (mem_addr !== eadr[i] || mem_wstrb !== estb[i] || mem_wdata !== ewd[i]) begin
                n_err++;
                $display("FAIL st%0d_lanes: addr %h strb %b wdata %h expected %h %b %h",
                         i, mem_addr, mem_wstrb, mem_wdata, eadr[i], estb[i], ewd[i]);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            n_cmp++;
            if ({done, fault, mem_req_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL st%0d_done: done/fault/valid %b expected 100", i, {done, fault, mem_req_valid});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL st_idle: busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [6];
        logic [31:0] adrs [6];
        logic [31:0] rdat [6];
        logic [31:0] exps [6];
        f3s[0] = 3'b000; adrs[0] = 32'h102; rdat[0] = 32'h12F45678; exps[0] = 32'hFFFFFFF4;
        f3s[1] = 3'b100; adrs[1] = 32'h102; rdat[1] = 32'h12F45678; exps[1] = 32'h000000F4;
        f3s[2] = 3'b101; adrs[2] = 32'h102; rdat[2] = 32'h12F45678; exps[2] = 32'h000012F4;
        f3s[3] = 3'b001; adrs[3] = 32'h100; rdat[3] = 32'h12348001; exps[3] = 32'hFFFF8001;
        f3s[4] = 3'b010; adrs[4] = 32'h100; rdat[4] = 32'h89ABCDEF; exps[4] = 32'h89ABCDEF;
        f3s[5] = 3'b100; adrs[5] = 32'h101; rdat[5] = 32'h12F45678; exps[5] = 32'h00000056;
        for (int i = 0; i < 6; i++) begin
            launch(1'b1, 1'b0, f3s[i], adrs[i], 32'hFFFFFFFF);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'd0 || mem_addr !== 32'h100) begin
                n_err++;
                $display("FAIL ld%0d_req: valid %b we %b strb %b addr %h expected 1 0 0000 00000100",
                         i, mem_req_valid, mem_we, mem_wstrb, mem_addr);
            end
            // A response coincident with the handshake must be ignored
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rdata     = ~rdat[i];
            @(negedge clk);
            mem_req_ready = 1'b0;
            n_cmp++;
            if ({busy, done, mem_req_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL ld%0d_wait: busy/done/valid %b expected 100", i, {busy, done, mem_req_valid});
            end
            mem_rdata = rdat[i];
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'h0;
            n_cmp++;
            if ({done, fault} !== 2'b10 || load_data !== exps[i]) begin
                n_err++;
                $display("FAIL ld%0d_data: done/fault %b data %h expected 10 %h",
                         i, {done, fault}, load_data, exps[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_faults();
        logic        lds  [8];
        logic        sts  [8];
        logic [2:0]  f3s  [8];
        logic [31:0] adrs [8];
        logic        efl  [8];
        lds[0] = 1; sts[0] = 0; f3s[0] = 3'b010; adrs[0] = 32'h102; efl[0] = 1;
        lds[1] = 1; sts[1] = 0; f3s[1] = 3'b001; adrs[1] = 32'h101; efl[1] = 1;
        lds[2] = 0; sts[2] = 1; f3s[2] = 3'b001; adrs[2] = 32'h103; efl[2] = 1;
        lds[3] = 0; sts[3] = 1; f3s[3] = 3'b010; adrs[3] = 32'h101; efl[3] = 1;
        lds[4] = 1; sts[4] = 0; f3s[4] = 3'b011; adrs[4] = 32'h100; efl[4] = 1;
        lds[5] = 0; sts[5] = 1; f3s[5] = 3'b100; adrs[5] = 32'h100; efl[5] = 1;
        lds[6] = 1; sts[6] = 1; f3s[6] = 3'b010; adrs[6] = 32'h100; efl[6] = 1;
        lds[7] = 0; sts[7] = 0; f3s[7] = 3'b010; adrs[7] = 32'h100; efl[7] = 0;
        for (int i = 0; i < 8; i++) begin
            launch(lds[i], sts[i], f3s[i], adrs[i], 32'h55AA55AA);
            n_cmp++;
            if (done !== 1'b1 || fault !== efl[i] || mem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flt%0d_done: done %b fault %b valid %b expected 1 %b 0",
                         i, done, fault, mem_req_valid, efl[i]);
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, done, fault, mem_req_valid} !== 4'b0000 || load_data !== 32'h00000056) begin
                n_err++;
                $display("FAIL flt%0d_after: b/d/f/v %b data %h expected 0000 00000056",
                         i, {busy, done, fault, mem_req_valid}, load_data);
            end
        end
    endtask

    task automatic test_stall();
        launch(1'b0, 1'b1, 3'b010, 32'h204, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (mem_req_valid !== 1'b1 || done !== 1'b0 || mem_addr !== 32'h204 ||
                mem_wstrb !== 4'b1111 || mem_wdata !== 32'h11223344 || mem_we !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d: v %b d %b addr %h strb %b wd %h we %b expected 1 0 204 1111 11223344 1",
                         i, mem_req_valid, done, mem_addr, mem_wstrb, mem_wdata, mem_we);
            end
            start      = (i % 2 == 0);
            is_load    = 1'b1;
            funct3     = 3'b000;
            alu_result = 32'h300;
            @(negedge clk);
        end
        start         = 1'b0;
        is_load       = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_cmp++;
        if ({done, fault} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_done: done/fault %b expected 10", {done, fault});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, mem_req_valid} !== 2'b00 || mem_addr !== 32'h204) begin
            n_err++;
            $display("FAIL stall_noqueue: busy/valid %b addr %h expected 00 204", {busy, mem_req_valid}, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        launch(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || load_data !== 32'h00000056) begin
            n_err++;
            $display("FAIL rst_pre: busy %b data %h expected 1 00000056", busy, load_data);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, fault, mem_req_valid, mem_we} !== 5'b0 || mem_addr !== 32'd0 ||
            mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 || load_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_async: ctl %b addr %h wd %h strb %b data %h expected all 0",
                     {busy, done, fault, mem_req_valid, mem_we}, mem_addr, mem_wdata, mem_wstrb, load_data);
        end
        @(negedge clk);
        reset         = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFEBABE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00 || load_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_discard: busy/done %b data %h expected 00 0", {busy, done}, load_data);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || load_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_nodone: done %b data %h expected 0 0", done, load_data);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        start         = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        funct3        = 3'b000;
        alu_result    = 32'h0;
        store_data    = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        test_reset();
        test_store_b2b();
        test_loads();
        test_faults();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
